// File: rtl/ocx_vc_cmd_credit_bridge.sv
// ocx_vc_cmd_credit_bridge
// Buffers AFU commands and 64B data beats in local FIFOs and issues them on the
// TLX VC3/DCP3 channel against TLX-granted credits. The AFU sees the local FIFO
// depths as its initial credits and gets one credit back per entry popped.
// Data beats only issue once the command that owns them has issued.
// Optional feature: define OCX_BRIDGE_RESYNC_EN to enable the credit resync
// state driven by cfg_tlx_resync_credits.
module ocx_vc_cmd_credit_bridge #(
  parameter int CMD_W      = 168,
  parameter int CMD_DEPTH  = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             afu_tlx_cmd_valid,
  input  logic [CMD_W-1:0] afu_tlx_cmd_payload,
  input  logic [2:0]       afu_tlx_cmd_beats,
  input  logic             afu_tlx_cdata_valid,
  input  logic [511:0]     afu_tlx_cdata_bus,
  input  logic             afu_tlx_cdata_bdi,
  output logic [3:0]       tlx_afu_cmd_initial_credit,
  output logic [5:0]       tlx_afu_cmd_data_initial_credit,
  output logic             tlx_afu_cmd_credit,
  output logic             tlx_afu_cmd_data_credit,
  input  logic [3:0]       tlx_afu_vc3_initial_credit,
  input  logic [5:0]       tlx_afu_dcp3_initial_credit,
  input  logic             tlx_afu_vc3_credit,
  input  logic             tlx_afu_dcp3_credit,
  input  logic             cfg_tlx_resync_credits,
  output logic             afu_tlx_vc3_valid,
  output logic [CMD_W-1:0] afu_tlx_vc3_payload,
  output logic             afu_tlx_dcp3_data_valid,
  output logic [511:0]     afu_tlx_dcp3_data_bus,
  output logic             afu_tlx_dcp3_data_bdi,
  output logic             bridge_err
);

  localparam int CA_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CC_W = $clog2(CMD_DEPTH + 1);
  localparam int DA_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int DC_W = $clog2(DATA_DEPTH + 1);
  // Released-beat counter is nominally bounded by 4*CMD_DEPTH; two spare bits
  // give headroom when the AFU runs its data behind its commands.
  localparam int RB_W = $clog2(4 * CMD_DEPTH + 1) + 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   issue_en;
  logic   reload_cr;

  // Command FIFO storage: payload plus the (clamped) beat count it owns.
  logic [CMD_W-1:0] cmd_mem_q   [CMD_DEPTH];
  logic [2:0]       cmd_beats_q [CMD_DEPTH];
  logic [CA_W-1:0]  cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CC_W-1:0]  cmd_cnt_q, cmd_cnt_d;

  // Data FIFO storage: {bdi, bus}.
  logic [512:0]     data_mem_q [DATA_DEPTH];
  logic [DA_W-1:0]  data_wr_q, data_wr_d, data_rd_q, data_rd_d;
  logic [DC_W-1:0]  data_cnt_q, data_cnt_d;

  logic [3:0]       vc_cr_q, vc_cr_d;
  logic [5:0]       dc_cr_q, dc_cr_d;
  logic [RB_W-1:0]  rel_beats_q, rel_beats_d, rel_eff;
  logic             err_q, err_d;
  logic             vc_ovf, dc_ovf;

  logic             cmd_full, cmd_pop, cmd_push_ok, cmd_drop, beats_bad;
  logic [2:0]       cmd_beats_clamped;
  logic             data_full, data_pop, data_push_ok, data_drop;

  logic             vc3_valid_q;
  logic [CMD_W-1:0] vc3_payload_q;
  logic             dcp3_valid_q;
  logic [511:0]     dcp3_bus_q;
  logic             dcp3_bdi_q;
  logic             cmd_credit_q;
  logic             data_credit_q;

`ifndef OCX_BRIDGE_RESYNC_EN
  logic unused_resync;
  assign unused_resync = cfg_tlx_resync_credits;
`endif

  function automatic logic [CA_W-1:0] cmd_ptr_inc(input logic [CA_W-1:0] p);
    return (p == CA_W'(CMD_DEPTH - 1)) ? '0 : p + CA_W'(1);
  endfunction

  function automatic logic [DA_W-1:0] data_ptr_inc(input logic [DA_W-1:0] p);
    return (p == DA_W'(DATA_DEPTH - 1)) ? '0 : p + DA_W'(1);
  endfunction

  assign tlx_afu_cmd_initial_credit      = 4'(CMD_DEPTH);
  assign tlx_afu_cmd_data_initial_credit = 6'(DATA_DEPTH);

  // Phase control: credit load in INIT/RESYNC, issue only in RUN.
  always_comb begin
    state_d   = state_q;
    issue_en  = 1'b0;
    reload_cr = 1'b0;
    case (state_q)
      ST_INIT: begin
        reload_cr = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        issue_en = 1'b1;
`ifdef OCX_BRIDGE_RESYNC_EN
        if (cfg_tlx_resync_credits) begin
          state_d = ST_RESYNC;
        end
`endif
      end
      ST_RESYNC: begin
        reload_cr = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Issue decisions; data may ride on beats released by this cycle's command.
  always_comb begin
    cmd_full  = (cmd_cnt_q == CC_W'(CMD_DEPTH));
    data_full = (data_cnt_q == DC_W'(DATA_DEPTH));
    cmd_pop   = issue_en && (cmd_cnt_q != '0) && (vc_cr_q != '0);
    rel_eff   = rel_beats_q;
    if (cmd_pop) begin
      rel_eff = rel_beats_q + RB_W'(cmd_beats_q[cmd_rd_q]);
    end
    data_pop = issue_en && (data_cnt_q != '0) && (dc_cr_q != '0) && (rel_eff != '0);
    rel_beats_d = rel_eff - RB_W'(data_pop);

    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    cmd_push_ok       = afu_tlx_cmd_valid && (!cmd_full || cmd_pop);
    cmd_drop          = afu_tlx_cmd_valid && cmd_full && !cmd_pop;
    beats_bad         = afu_tlx_cmd_valid && (afu_tlx_cmd_beats > 3'd4);
    cmd_beats_clamped = beats_bad ? 3'd4 : afu_tlx_cmd_beats;
    data_push_ok      = afu_tlx_cdata_valid && (!data_full || data_pop);
    data_drop         = afu_tlx_cdata_valid && data_full && !data_pop;
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    cmd_wr_d   = cmd_push_ok ? cmd_ptr_inc(cmd_wr_q) : cmd_wr_q;
    cmd_rd_d   = cmd_pop ? cmd_ptr_inc(cmd_rd_q) : cmd_rd_q;
    data_wr_d  = data_push_ok ? data_ptr_inc(data_wr_q) : data_wr_q;
    data_rd_d  = data_pop ? data_ptr_inc(data_rd_q) : data_rd_q;
    cmd_cnt_d  = cmd_cnt_q;
    data_cnt_d = data_cnt_q;
    case ({cmd_push_ok, cmd_pop})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CC_W'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - CC_W'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase
    case ({data_push_ok, data_pop})
      2'b10:   data_cnt_d = data_cnt_q + DC_W'(1);
      2'b01:   data_cnt_d = data_cnt_q - DC_W'(1);
      default: data_cnt_d = data_cnt_q;
    endcase
  end

  // TLX credit counters: reload, saturating return, consume; return+consume cancel.
  always_comb begin
    vc_cr_d = vc_cr_q;
    dc_cr_d = dc_cr_q;
    vc_ovf  = 1'b0;
    dc_ovf  = 1'b0;
    if (reload_cr) begin
      vc_cr_d = tlx_afu_vc3_initial_credit;
      dc_cr_d = tlx_afu_dcp3_initial_credit;
    end else begin
      if (tlx_afu_vc3_credit && !cmd_pop) begin
        if (vc_cr_q == 4'hF) vc_ovf = 1'b1;
        else                 vc_cr_d = vc_cr_q + 4'd1;
      end else if (!tlx_afu_vc3_credit && cmd_pop) begin
        vc_cr_d = vc_cr_q - 4'd1;
      end
      if (tlx_afu_dcp3_credit && !data_pop) begin
        if (dc_cr_q == 6'h3F) dc_ovf = 1'b1;
        else                  dc_cr_d = dc_cr_q + 6'd1;
      end else if (!tlx_afu_dcp3_credit && data_pop) begin
        dc_cr_d = dc_cr_q - 6'd1;
      end
    end
    err_d = err_q | cmd_drop | data_drop | beats_bad | vc_ovf | dc_ovf;
  end

  // Control state, counters and pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      data_wr_q   <= '0;
      data_rd_q   <= '0;
      data_cnt_q  <= '0;
      vc_cr_q     <= '0;
      dc_cr_q     <= '0;
      rel_beats_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_cnt_q   <= cmd_cnt_d;
      data_wr_q   <= data_wr_d;
      data_rd_q   <= data_rd_d;
      data_cnt_q  <= data_cnt_d;
      vc_cr_q     <= vc_cr_d;
      dc_cr_q     <= dc_cr_d;
      rel_beats_q <= rel_beats_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage writes; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (cmd_push_ok) begin
      cmd_mem_q[cmd_wr_q]   <= afu_tlx_cmd_payload;
      cmd_beats_q[cmd_wr_q] <= cmd_beats_clamped;
    end
    if (data_push_ok) begin
      data_mem_q[data_wr_q] <= {afu_tlx_cdata_bdi, afu_tlx_cdata_bus};
    end
  end

  // Registered channel outputs and AFU credit pulses; zero when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vc3_valid_q   <= 1'b0;
      vc3_payload_q <= '0;
      dcp3_valid_q  <= 1'b0;
      dcp3_bus_q    <= '0;
      dcp3_bdi_q    <= 1'b0;
      cmd_credit_q  <= 1'b0;
      data_credit_q <= 1'b0;
    end else begin
      vc3_valid_q   <= cmd_pop;
      vc3_payload_q <= cmd_pop ? cmd_mem_q[cmd_rd_q] : '0;
      dcp3_valid_q  <= data_pop;
      dcp3_bus_q    <= data_pop ? data_mem_q[data_rd_q][511:0] : '0;
      dcp3_bdi_q    <= data_pop ? data_mem_q[data_rd_q][512] : 1'b0;
      cmd_credit_q  <= cmd_pop;
      data_credit_q <= data_pop;
    end
  end

  assign afu_tlx_vc3_valid       = vc3_valid_q;
  assign afu_tlx_vc3_payload     = vc3_payload_q;
  assign afu_tlx_dcp3_data_valid = dcp3_valid_q;
  assign afu_tlx_dcp3_data_bus   = dcp3_bus_q;
  assign afu_tlx_dcp3_data_bdi   = dcp3_bdi_q;
  assign tlx_afu_cmd_credit      = cmd_credit_q;
  assign tlx_afu_cmd_data_credit = data_credit_q;
  assign bridge_err              = err_q;

endmodule

// File: tb/tb_ocx_vc_cmd_credit_bridge.sv
// Testbench for ocx_vc_cmd_credit_bridge: directed scenarios plus a random run,
// all checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_ocx_vc_cmd_credit_bridge;
  localparam int CMD_W      = 168;
  localparam int CMD_DEPTH  = 8;
  localparam int DATA_DEPTH = 16;
  localparam int VW         = CMD_W + 518;
  localparam int PH_INIT    = 0;
  localparam int PH_RUN     = 1;
  localparam int PH_RESYNC  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             afu_tlx_cmd_valid = 1'b0;
  logic [CMD_W-1:0] afu_tlx_cmd_payload = '0;
  logic [2:0]       afu_tlx_cmd_beats = '0;
  logic             afu_tlx_cdata_valid = 1'b0;
  logic [511:0]     afu_tlx_cdata_bus = '0;
  logic             afu_tlx_cdata_bdi = 1'b0;
  logic [3:0]       tlx_afu_cmd_initial_credit;
  logic [5:0]       tlx_afu_cmd_data_initial_credit;
  logic             tlx_afu_cmd_credit;
  logic             tlx_afu_cmd_data_credit;
  logic [3:0]       tlx_afu_vc3_initial_credit = '0;
  logic [5:0]       tlx_afu_dcp3_initial_credit = '0;
  logic             tlx_afu_vc3_credit = 1'b0;
  logic             tlx_afu_dcp3_credit = 1'b0;
  logic             cfg_tlx_resync_credits = 1'b0;
  logic             afu_tlx_vc3_valid;
  logic [CMD_W-1:0] afu_tlx_vc3_payload;
  logic             afu_tlx_dcp3_data_valid;
  logic [511:0]     afu_tlx_dcp3_data_bus;
  logic             afu_tlx_dcp3_data_bdi;
  logic             bridge_err;

  int checks = 0;
  int errors = 0;

  ocx_vc_cmd_credit_bridge #(
    .CMD_W(CMD_W), .CMD_DEPTH(CMD_DEPTH), .DATA_DEPTH(DATA_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .afu_tlx_cmd_valid(afu_tlx_cmd_valid), .afu_tlx_cmd_payload(afu_tlx_cmd_payload),
    .afu_tlx_cmd_beats(afu_tlx_cmd_beats), .afu_tlx_cdata_valid(afu_tlx_cdata_valid),
    .afu_tlx_cdata_bus(afu_tlx_cdata_bus), .afu_tlx_cdata_bdi(afu_tlx_cdata_bdi),
    .tlx_afu_cmd_initial_credit(tlx_afu_cmd_initial_credit),
    .tlx_afu_cmd_data_initial_credit(tlx_afu_cmd_data_initial_credit),
    .tlx_afu_cmd_credit(tlx_afu_cmd_credit), .tlx_afu_cmd_data_credit(tlx_afu_cmd_data_credit),
    .tlx_afu_vc3_initial_credit(tlx_afu_vc3_initial_credit),
    .tlx_afu_dcp3_initial_credit(tlx_afu_dcp3_initial_credit),
    .tlx_afu_vc3_credit(tlx_afu_vc3_credit), .tlx_afu_dcp3_credit(tlx_afu_dcp3_credit),
    .cfg_tlx_resync_credits(cfg_tlx_resync_credits),
    .afu_tlx_vc3_valid(afu_tlx_vc3_valid), .afu_tlx_vc3_payload(afu_tlx_vc3_payload),
    .afu_tlx_dcp3_data_valid(afu_tlx_dcp3_data_valid), .afu_tlx_dcp3_data_bus(afu_tlx_dcp3_data_bus),
    .afu_tlx_dcp3_data_bdi(afu_tlx_dcp3_data_bdi), .bridge_err(bridge_err)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct { logic [CMD_W-1:0] pl; int beats; } cmd_t;
  typedef struct { logic [511:0] bus; logic bdi; } dat_t;
  cmd_t mcq[$];
  dat_t mdq[$];
  int   m_vc, m_dc, m_rel, m_phase;
  logic m_err;

  logic             e_vc3v, e_dv, e_bdi, e_ccr, e_dcr, e_err;
  logic [CMD_W-1:0] e_pl;
  logic [511:0]     e_bus;
  logic [VW-1:0]    obs_vec, exp_vec;

  assign obs_vec = {afu_tlx_vc3_valid, afu_tlx_vc3_payload, afu_tlx_dcp3_data_valid,
                    afu_tlx_dcp3_data_bdi, afu_tlx_dcp3_data_bus, tlx_afu_cmd_credit,
                    tlx_afu_cmd_data_credit, bridge_err};
  assign exp_vec = {e_vc3v, e_pl, e_dv, e_bdi, e_bus, e_ccr, e_dcr, e_err};

  // Advance the model by one clock using the inputs the DUT sees at this edge.
  task automatic model_step();
    bit   cpop, dpop;
    int   rel_eff;
    cmd_t hc;
    dat_t hd;
    cmd_t nc;
    dat_t nd;
    if (reset) begin
      mcq.delete(); mdq.delete();
      m_vc = 0; m_dc = 0; m_rel = 0; m_err = 1'b0; m_phase = PH_INIT;
      e_vc3v = 0; e_pl = '0; e_dv = 0; e_bdi = 0; e_bus = '0; e_ccr = 0; e_dcr = 0; e_err = 0;
      return;
    end
    cpop = (m_phase == PH_RUN) && (mcq.size() > 0) && (m_vc > 0);
    rel_eff = m_rel;
    if (cpop) begin
      hc = mcq.pop_front();
      rel_eff += hc.beats;
    end
    dpop = (m_phase == PH_RUN) && (mdq.size() > 0) && (m_dc > 0) && (rel_eff > 0);
    if (dpop) hd = mdq.pop_front();
    e_vc3v = cpop;
    e_pl   = cpop ? hc.pl : '0;
    e_dv   = dpop;
    e_bus  = dpop ? hd.bus : '0;
    e_bdi  = dpop ? hd.bdi : 1'b0;
    e_ccr  = cpop;
    e_dcr  = dpop;
    if (m_phase != PH_RUN) begin
      m_vc = int'(tlx_afu_vc3_initial_credit);
      m_dc = int'(tlx_afu_dcp3_initial_credit);
    end else begin
      if (tlx_afu_vc3_credit && !cpop) begin
        if (m_vc == 15) m_err = 1'b1; else m_vc++;
      end else if (!tlx_afu_vc3_credit && cpop) m_vc--;
      if (tlx_afu_dcp3_credit && !dpop) begin
        if (m_dc == 63) m_err = 1'b1; else m_dc++;
      end else if (!tlx_afu_dcp3_credit && dpop) m_dc--;
    end
    m_rel = rel_eff - (dpop ? 1 : 0);
    if (afu_tlx_cmd_valid) begin
      if (afu_tlx_cmd_beats > 4) m_err = 1'b1;
      if (mcq.size() < CMD_DEPTH) begin
        nc.pl = afu_tlx_cmd_payload;
        nc.beats = (afu_tlx_cmd_beats > 4) ? 4 : int'(afu_tlx_cmd_beats);
        mcq.push_back(nc);
      end else m_err = 1'b1;
    end
    if (afu_tlx_cdata_valid) begin
      if (mdq.size() < DATA_DEPTH) begin
        nd.bus = afu_tlx_cdata_bus;
        nd.bdi = afu_tlx_cdata_bdi;
        mdq.push_back(nd);
      end else m_err = 1'b1;
    end
    e_err = m_err;
    if (m_phase != PH_RUN) m_phase = PH_RUN;
`ifdef OCX_BRIDGE_RESYNC_EN
    else if (cfg_tlx_resync_credits) m_phase = PH_RESYNC;
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle();
    afu_tlx_cmd_valid = 0; afu_tlx_cdata_valid = 0; afu_tlx_cmd_beats = 0;
    tlx_afu_vc3_credit = 0; tlx_afu_dcp3_credit = 0; cfg_tlx_resync_credits = 0;
  endtask

  task automatic do_reset(input logic [3:0] vc, input logic [5:0] dc);
    idle();
    reset = 1;
    tlx_afu_vc3_initial_credit = vc;
    tlx_afu_dcp3_initial_credit = dc;
    tick();
    tick();
    reset = 0;
  endtask

  function automatic logic [CMD_W-1:0] rand_pl();
    logic [CMD_W-1:0] r;
    for (int k = 0; k < CMD_W; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [511:0] rand_bus();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_cmd(input logic [CMD_W-1:0] pl, input logic [2:0] beats);
    afu_tlx_cmd_valid = 1; afu_tlx_cmd_payload = pl; afu_tlx_cmd_beats = beats;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_outputs cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (tlx_afu_cmd_initial_credit !== 4'd8 || tlx_afu_cmd_data_initial_credit !== 6'd16) begin
      errors++;
      $display("FAIL initial_credit: got %0d/%0d want 8/16", tlx_afu_cmd_initial_credit,
               tlx_afu_cmd_data_initial_credit);
    end
  endtask

  task automatic test_credit_gating();
    int nv = 0, nc = 0, third = -1;
    do_reset(4'd2, 6'd8);
    for (int i = 0; i < 14; i++) begin
      idle();
      if (i < 3) push_cmd(rand_pl(), 3'd0);
      tlx_afu_vc3_credit = (i == 9);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL gating_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (afu_tlx_vc3_valid) begin nv++; if (nv == 3) third = i; end
      if (tlx_afu_cmd_credit) nc++;
      if (i == 8) begin
        checks++;
        if (nv != 2) begin errors++; $display("FAIL gating_held: got %0d issues want 2", nv); end
      end
    end
    checks++;
    if (nv != 3 || nc != 3 || third != 10) begin
      errors++;
      $display("FAIL gating_total: got issues=%0d credits=%0d third_at=%0d want 3/3/10", nv, nc, third);
    end
  endtask

  task automatic test_ordering();
    logic [CMD_W-1:0] p;
    logic [511:0] d0, d1, x;
    int ndv = 0;
    p = rand_pl(); d0 = rand_bus(); d1 = rand_bus(); x = rand_bus();
    do_reset(4'd4, 6'd8);
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 0) begin
        push_cmd(p, 3'd2);
        afu_tlx_cdata_valid = 1; afu_tlx_cdata_bus = d0; afu_tlx_cdata_bdi = 0;
      end
      if (i == 1) begin
        afu_tlx_cdata_valid = 1; afu_tlx_cdata_bus = d1; afu_tlx_cdata_bdi = 1;
      end
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL order_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (i == 0) begin
        checks++;
        if (afu_tlx_vc3_valid !== 1'b0 || afu_tlx_dcp3_data_valid !== 1'b0) begin
          errors++; $display("FAIL order_early: got vc3=%b dcp3=%b want 0/0", afu_tlx_vc3_valid, afu_tlx_dcp3_data_valid);
        end
      end
      if (i == 1) begin
        checks++;
        if (afu_tlx_vc3_valid !== 1'b1 || afu_tlx_vc3_payload !== p || afu_tlx_dcp3_data_valid !== 1'b1 ||
            afu_tlx_dcp3_data_bus !== d0) begin
          errors++; $display("FAIL order_n2: got vc3=%b dcp3=%b want 1/1 with first beat", afu_tlx_vc3_valid, afu_tlx_dcp3_data_valid);
        end
      end
      if (i == 2) begin
        checks++;
        if (afu_tlx_dcp3_data_valid !== 1'b1 || afu_tlx_dcp3_data_bus !== d1 || afu_tlx_dcp3_data_bdi !== 1'b1) begin
          errors++; $display("FAIL order_n3: got dcp3=%b bdi=%b want 1/1 with second beat", afu_tlx_dcp3_data_valid, afu_tlx_dcp3_data_bdi);
        end
      end
    end
    // A data beat ahead of its command must wait for the command.
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 0) begin afu_tlx_cdata_valid = 1; afu_tlx_cdata_bus = x; afu_tlx_cdata_bdi = 0; end
      if (i == 6) push_cmd(rand_pl(), 3'd1);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL hold_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (i < 7 && afu_tlx_dcp3_data_valid) ndv++;
      if (i == 7) begin
        checks++;
        if (ndv != 0 || afu_tlx_vc3_valid !== 1'b1 || afu_tlx_dcp3_data_valid !== 1'b1 || afu_tlx_dcp3_data_bus !== x) begin
          errors++; $display("FAIL hold_release: got early=%0d vc3=%b dcp3=%b want 0/1/1", ndv, afu_tlx_vc3_valid, afu_tlx_dcp3_data_valid);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [CMD_W-1:0] pls [9];
    int nv = 0;
    do_reset(4'd0, 6'd8);
    for (int i = 0; i < 22; i++) begin
      idle();
      if (i < 9) begin pls[i] = rand_pl(); push_cmd(pls[i], 3'd0); end
      tlx_afu_vc3_credit = (i >= 10 && i < 18);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL ovf_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (afu_tlx_vc3_valid) begin
        checks++;
        if (nv >= 8 || afu_tlx_vc3_payload !== pls[nv]) begin
          errors++; $display("FAIL ovf_order: issue %0d payload out of order or extra", nv);
        end
        nv++;
      end
      if (i == 9) begin
        checks++;
        if (bridge_err !== 1'b1 || nv != 0) begin
          errors++; $display("FAIL ovf_err: got err=%b issues=%0d want 1/0", bridge_err, nv);
        end
      end
    end
    checks++;
    if (nv != 8) begin errors++; $display("FAIL ovf_count: got %0d issues want 8", nv); end
  endtask

  task automatic test_simultaneous();
    int nv = 0;
    do_reset(4'd1, 6'd8);
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i == 0 || i == 2 || i == 3) push_cmd(rand_pl(), 3'd0);
      tlx_afu_vc3_credit = (i == 1);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL simul_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (afu_tlx_vc3_valid) nv++;
    end
    checks++;
    if (nv != 2) begin errors++; $display("FAIL simul_count: got %0d issues want 2", nv); end
    do_reset(4'd15, 6'd8);
    for (int i = 0; i < 4; i++) begin
      idle();
      tlx_afu_vc3_credit = (i == 1);
      tick();
      checks++;
      if (bridge_err !== (i >= 1)) begin
        errors++; $display("FAIL vc_saturate cyc%0d: got err=%b want %b", i, bridge_err, (i >= 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0, nc = 0;
    do_reset(4'd0, 6'd8);
    for (int i = 0; i < 24; i++) begin
      idle();
      if (i < 4 || (i >= 11 && i < 15)) push_cmd(rand_pl(), 3'd0);
      tlx_afu_vc3_credit = (i == 4);
      reset = (i == 5);
      if (i == 5) tlx_afu_vc3_initial_credit = 4'd3;
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL rstmid_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (i == 5) begin
        checks++;
        if (obs_vec !== '0) begin errors++; $display("FAIL rstmid_zero: got %h want 0", obs_vec); end
      end
      if (i >= 5 && afu_tlx_vc3_valid) nv++;
      if (i >= 5 && i < 11 && tlx_afu_cmd_credit) nc++;
    end
    checks++;
    if (nv != 3 || nc != 0) begin
      errors++; $display("FAIL rstmid_after: got issues=%0d flushed_pulses=%0d want 3/0", nv, nc);
    end
  endtask

  task automatic test_resync();
    int nv = 0;
    do_reset(4'd0, 6'd8);
    for (int i = 0; i < 15; i++) begin
      idle();
      if (i < 4) push_cmd(rand_pl(), 3'd0);
      if (i == 6) begin cfg_tlx_resync_credits = 1; tlx_afu_vc3_initial_credit = 4'd4; end
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL resync_cycle cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      if (afu_tlx_vc3_valid) nv++;
`ifdef OCX_BRIDGE_RESYNC_EN
      if (i >= 7 && i <= 11) begin
        checks++;
        if (afu_tlx_vc3_valid !== (i >= 8)) begin
          errors++; $display("FAIL resync_timing cyc%0d: got %b want %b", i, afu_tlx_vc3_valid, (i >= 8));
        end
      end
`endif
    end
    checks++;
`ifdef OCX_BRIDGE_RESYNC_EN
    if (nv != 4) begin errors++; $display("FAIL resync_count: got %0d want 4", nv); end
`else
    if (nv != 0) begin errors++; $display("FAIL resync_count: got %0d want 0", nv); end
`endif
  endtask

  task automatic test_random();
    do_reset(4'($urandom_range(1, 15)), 6'($urandom_range(1, 63)));
    for (int i = 0; i < 400; i++) begin
      idle();
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) < 30)
        push_cmd(rand_pl(), ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)));
      if ($urandom_range(0, 99) < 75) begin
        afu_tlx_cdata_valid = 1; afu_tlx_cdata_bus = rand_bus(); afu_tlx_cdata_bdi = 1'($urandom_range(0, 1));
      end
      tlx_afu_vc3_credit  = ($urandom_range(0, 99) < 30);
      tlx_afu_dcp3_credit = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 49) == 0) begin
        cfg_tlx_resync_credits = 1;
        tlx_afu_vc3_initial_credit = 4'($urandom_range(0, 15));
        tlx_afu_dcp3_initial_credit = 6'($urandom_range(0, 63));
      end
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_credit_gating();
    test_ordering();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_resync();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
